conv_triplet_serializer: RTL and testbench
==========================================

CONV_TRIPLET_SERIALIZER -- requirements
Module: conv_triplet_serializer

Interface
REQ-001 Parameter LEN_SHORT, default 132: bytes per subblock when len_sel=0 (1056-bit code block).
REQ-002 Parameter LEN_LONG, default 768: bytes per subblock when len_sel=1 (6144-bit code block).
REQ-003 Port: clk, input, 1, the only clock; all logic on rising edge.
REQ-004 Port: reset, input, 1, synchronous active-high reset.
REQ-005 Port: computation_done, input, 1, level from convolutional encoder; subblock data ready.
REQ-006 Port: len_sel, input, 1, code block length select; same encoding as the encoder's code_block_length.
REQ-007 Port: q0 / q1 / q2, input, 8 each, show-ahead heads of the encoder's three subblock FIFOs.
REQ-008 Port: rdreq_subblock, output, 1, pops one byte from all three subblock FIFOs at once.
REQ-009 Port: out_data, output, 8, serialized byte.
REQ-010 Port: out_valid, output, 1, out_data valid.
REQ-011 Port: out_ready, input, 1, consumer accepts the byte.
REQ-012 Port: out_sel, output, 2, source subblock of out_data (0, 1, 2).
REQ-013 Port: out_last, output, 1, final byte of frame.
REQ-014 Port: busy, output, 1, high in any state except IDLE.
REQ-015 Port: frame_done, output, 1, one-cycle pulse after the last handshake.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, EMIT0, EMIT1, EMIT2 and DONE.
REQ-017 IDLE: computation_done=1 -> latch len_sel into N (LEN_SHORT or LEN_LONG), clear triplet counter, go to LOAD.
REQ-018 LOAD: assert rdreq_subblock for exactly one cycle, capture q0/q1/q2 into hold registers on the same edge, go to EMIT0.
REQ-019 rdreq_subblock SHALL be asserted only in LOAD and SHALL total exactly N pulses per frame.
REQ-020 EMITk (k=0..2): out_valid=1, out_data=hold[k], out_sel=k; on out_valid&out_ready advance to EMITk+1; otherwise hold out_data and out_sel stable.
REQ-021 On a handshake in EMIT2: if triplet counter < N-1, increment the counter and go to LOAD; else go to DONE.
REQ-022 out_last SHALL be 1 only in EMIT2 when triplet counter = N-1.
REQ-023 Byte order per frame: q0[0], q1[0], q2[0], q0[1], ... q2[N-1]; 3N bytes total.
REQ-024 DONE: pulse frame_done for one cycle on entry; stay in DONE until computation_done=0, then go to IDLE (no retrigger on a held level).
REQ-025 The triplet counter SHALL be 10 bits; N-1 (max 767) SHALL never wrap it.
REQ-026 Changes on len_sel mid-frame SHALL be ignored.
REQ-027 Changes on computation_done outside IDLE and DONE SHALL be ignored.
REQ-028 Throughput SHALL be 3 bytes per 4 cycles with out_ready held high (one LOAD bubble per triplet).

Reset
REQ-029 reset=1 SHALL set state=IDLE; rdreq_subblock, out_valid, out_last, busy and frame_done to 0; out_data, out_sel, hold registers and counter to 0.
REQ-030 Reset mid-frame SHALL abort without a further rdreq_subblock pulse; the next frame starts only on computation_done in IDLE.
REQ-031 reset SHALL have priority over every other input in the same cycle.

Structure
REQ-032 The shared encoder package SHALL hold the state encoding, LEN_SHORT/LEN_LONG and the len_sel encoding.
REQ-033 There SHALL be no sub-module: one FSM plus a 24-bit hold register and a 10-bit counter.

Verification
REQ-034 len_sel=0, out_ready=1, FIFOs preloaded with bytes i, i+0x40, i+0x80 -> 396 bytes in the order of REQ-023, 132 rdreq pulses, out_last on byte 396, frame_done one cycle later.
REQ-035 len_sel=1 -> 2304 bytes and 768 rdreq pulses; the counter reaches 767 without wrapping.
REQ-036 out_ready toggling randomly -> out_data and out_sel stable while stalled; no lost or duplicated bytes; rdreq count unchanged.
REQ-037 Reset asserted after byte 50 -> next cycle all outputs 0 and no rdreq; a fresh frame then completes correctly.
REQ-038 computation_done held high after the frame -> exactly one frame_done; a new frame starts only after computation_done drops and rises again.

Source files
------------

// File: rtl/conv_triplet_serializer_pkg.sv
// conv_triplet_serializer_pkg: shared encoder constants, FSM state encoding and hold-register layout.
package conv_triplet_serializer_pkg;

    localparam int CTS_LEN_SHORT = 132;
    localparam int CTS_LEN_LONG  = 768;

    localparam logic LEN_SEL_SHORT = 1'b0;
    localparam logic LEN_SEL_LONG  = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_EMIT0 = 3'd2;
    localparam logic [2:0] ST_EMIT1 = 3'd3;
    localparam logic [2:0] ST_EMIT2 = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef struct packed {
        logic [7:0] b2;
        logic [7:0] b1;
        logic [7:0] b0;
    } triplet_t;

endpackage

// File: rtl/conv_triplet_serializer_if.sv
// conv_triplet_serializer_if: encoder FIFO heads, pop strobe and serialized byte handshake.
interface conv_triplet_serializer_if;
    logic       computation_done;
    logic       len_sel;
    logic [7:0] q0;
    logic [7:0] q1;
    logic [7:0] q2;
    logic       rdreq_subblock;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sel;
    logic       out_last;
    logic       busy;
    logic       frame_done;

    modport master (
        output computation_done, len_sel, q0, q1, q2, out_ready,
        input  rdreq_subblock, out_data, out_valid, out_sel, out_last, busy, frame_done
    );

    modport slave (
        input  computation_done, len_sel, q0, q1, q2, out_ready,
        output rdreq_subblock, out_data, out_valid, out_sel, out_last, busy, frame_done
    );
endinterface

// File: rtl/conv_triplet_serializer.sv
// conv_triplet_serializer: pops one triplet from the encoder's three subblock FIFOs and
// emits it as q0,q1,q2 bytes over a valid/ready handshake, N triplets per frame.
module conv_triplet_serializer
    import conv_triplet_serializer_pkg::*;
#(
    parameter int LEN_SHORT = CTS_LEN_SHORT,
    parameter int LEN_LONG  = CTS_LEN_LONG
) (
    input  logic                         clk,
    input  logic                         reset,
    conv_triplet_serializer_if.slave     bus
);

    localparam logic [9:0] LAST_SHORT = 10'(LEN_SHORT - 1);
    localparam logic [9:0] LAST_LONG  = 10'(LEN_LONG - 1);

    logic [2:0] r_state;
    logic       r_long;
    logic [9:0] r_cnt;
    triplet_t   r_hold;
    logic       r_frame_done;

    logic       w_emit;
    logic       w_hs;
    logic       w_last;
    logic [9:0] w_cnt_last;

    assign w_cnt_last = r_long ? LAST_LONG : LAST_SHORT;
    assign w_emit     = (r_state == ST_EMIT0) || (r_state == ST_EMIT1) || (r_state == ST_EMIT2);
    assign w_hs       = w_emit && bus.out_ready;
    assign w_last     = r_cnt == w_cnt_last;

    assign bus.out_valid      = w_emit;
    assign bus.out_sel        = (r_state == ST_EMIT1) ? 2'd1 : (r_state == ST_EMIT2) ? 2'd2 : 2'd0;
    assign bus.out_data       = !w_emit ? 8'd0 : (r_state == ST_EMIT0) ? r_hold.b0 :
                                (r_state == ST_EMIT1) ? r_hold.b1 : r_hold.b2;
    assign bus.out_last       = (r_state == ST_EMIT2) && w_last;
    assign bus.rdreq_subblock = r_state == ST_LOAD;
    assign bus.busy           = r_state != ST_IDLE;
    assign bus.frame_done     = r_frame_done;

    // Frame length is latched at start so len_sel may move freely mid-frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_long       <= 1'b0;
            r_cnt        <= 10'd0;
            r_hold       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.computation_done) begin
                    r_long  <= bus.len_sel == LEN_SEL_LONG;
                    r_cnt   <= 10'd0;
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_hold  <= '{b2: bus.q2, b1: bus.q1, b0: bus.q0};
                    r_state <= ST_EMIT0;
                end
                ST_EMIT0: if (w_hs) r_state <= ST_EMIT1;
                ST_EMIT1: if (w_hs) r_state <= ST_EMIT2;
                ST_EMIT2: if (w_hs) begin
                    if (w_last) begin
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 10'd1;
                        r_state <= ST_LOAD;
                    end
                end
                // A held computation_done level must drop before the next frame.
                ST_DONE: if (!bus.computation_done) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_triplet_serializer.sv
// tb_conv_triplet_serializer: table-driven start-up vectors plus randomized frames checked
// against a byte-stream model built directly from the FIFO contents.
module tb_conv_triplet_serializer;
    import conv_triplet_serializer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_triplet_serializer_if bus();

    conv_triplet_serializer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] f0 [0:767];
    logic [7:0] f1 [0:767];
    logic [7:0] f2 [0:767];
    logic [9:0] ptr;
    logic       fifo_clr;

    always @(posedge clk) ptr <= fifo_clr ? 10'd0 : ptr + {9'd0, bus.rdreq_subblock};

    assign bus.q0 = f0[ptr];
    assign bus.q1 = f1[ptr];
    assign bus.q2 = f2[ptr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        int t = k / 3;
        return (k % 3 == 0) ? f0[t] : (k % 3 == 1) ? f1[t] : f2[t];
    endfunction

    task automatic fill(input int n, input bit rnd);
        for (int i = 0; i < 768; i++) begin
            f0[i] = rnd ? 8'($urandom) : 8'(i);
            f1[i] = rnd ? 8'($urandom) : 8'(i + 8'h40);
            f2[i] = rnd ? 8'($urandom) : 8'(i + 8'h80);
        end
        if (n > 768) $display("fill length clipped");
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.out_data),  32'd0);
        chk({tag, "_sel"},   32'(bus.out_sel),   32'd0);
        chk({tag, "_last"},  32'(bus.out_last),  32'd0);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_fdone"}, 32'(bus.frame_done), 32'd0);
        chk({tag, "_rdreq"}, 32'(bus.rdreq_subblock), 32'd0);
        tick();
    endtask

    task automatic do_reset();
        bus.computation_done = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        tick();
        check_quiet("reset");
        reset = 1'b0;
    endtask

    // Streams one frame; abort_at >= 0 applies reset once that many bytes were accepted.
    task automatic run_frame(input bit ls, input bit rnd, input int abort_at);
        int n = ls ? 768 : 132;
        int k = 0;
        int rd = 0;
        int fd = 0;
        fill(n, rnd);
        bus.len_sel = ls;
        bus.computation_done = 1'b1;
        for (int cyc = 0; cyc < 20000 && k < 3 * n; cyc++) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd && cyc > 2) begin
                bus.len_sel = 1'($urandom);
                bus.computation_done = (3 * n - k <= 6) ? 1'b1 : 1'($urandom);
            end
            @(negedge clk);
            rd += int'(bus.rdreq_subblock);
            fd += int'(bus.frame_done);
            if (bus.out_valid) begin
                chk("data", 32'(bus.out_data), 32'(exp_byte(k)));
                chk("sel",  32'(bus.out_sel),  32'(k % 3));
                chk("last", 32'(bus.out_last), 32'(k == 3 * n - 1));
                if (bus.out_ready) k++;
            end
            tick();
            if (abort_at >= 0 && k == abort_at) break;
        end
        if (abort_at >= 0) begin
            chk("abort_bytes", 32'(k), 32'(abort_at));
            bus.out_ready = 1'b1;
            reset = 1'b1;
            tick();
            check_quiet("abort");
            chk("abort_rdreq", 32'(rd), 32'((abort_at + 2) / 3));
            reset = 1'b0;
            bus.computation_done = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("abort_idle_rdreq", 32'(bus.rdreq_subblock), 32'd0);
                tick();
            end
            return;
        end
        chk("bytes", 32'(k), 32'(3 * n));
        bus.computation_done = 1'b1;
        @(negedge clk);
        chk("frame_done_timing", 32'(bus.frame_done), 32'd1);
        fd += int'(bus.frame_done);
        tick();
        repeat (10) begin
            @(negedge clk);
            fd += int'(bus.frame_done);
            rd += int'(bus.rdreq_subblock);
            tick();
        end
        chk("frame_done_count", 32'(fd), 32'd1);
        chk("rdreq_count", 32'(rd), 32'(n));
        chk("busy_done_held", 32'(bus.busy), 32'd1);
        chk("valid_done_held", 32'(bus.out_valid), 32'd0);
        bus.computation_done = 1'b0;
        tick();
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_rdreq", 32'(bus.rdreq_subblock), 32'd0);
            tick();
        end
    endtask

    typedef struct {
        bit         cd;
        bit         ls;
        bit         rdy;
        bit         e_valid;
        logic [1:0] e_sel;
        logic [7:0] e_data;
        bit         e_rdreq;
        bit         e_busy;
        bit         e_last;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{cd: 0, ls: 0, rdy: 1, e_valid: 0, e_sel: 0, e_data: 8'h00, e_rdreq: 0, e_busy: 0, e_last: 0};
        vecs[1] = '{cd: 1, ls: 0, rdy: 1, e_valid: 0, e_sel: 0, e_data: 8'h00, e_rdreq: 0, e_busy: 0, e_last: 0};
        vecs[2] = '{cd: 1, ls: 0, rdy: 0, e_valid: 0, e_sel: 0, e_data: 8'h00, e_rdreq: 1, e_busy: 1, e_last: 0};
        vecs[3] = '{cd: 1, ls: 0, rdy: 0, e_valid: 1, e_sel: 0, e_data: 8'h00, e_rdreq: 0, e_busy: 1, e_last: 0};
        vecs[4] = '{cd: 0, ls: 1, rdy: 1, e_valid: 1, e_sel: 0, e_data: 8'h00, e_rdreq: 0, e_busy: 1, e_last: 0};
        vecs[5] = '{cd: 0, ls: 1, rdy: 1, e_valid: 1, e_sel: 1, e_data: 8'h40, e_rdreq: 0, e_busy: 1, e_last: 0};
        vecs[6] = '{cd: 0, ls: 1, rdy: 1, e_valid: 1, e_sel: 2, e_data: 8'h80, e_rdreq: 0, e_busy: 1, e_last: 0};
        vecs[7] = '{cd: 0, ls: 0, rdy: 0, e_valid: 0, e_sel: 0, e_data: 8'h00, e_rdreq: 1, e_busy: 1, e_last: 0};
        vecs[8] = '{cd: 0, ls: 0, rdy: 1, e_valid: 1, e_sel: 0, e_data: 8'h01, e_rdreq: 0, e_busy: 1, e_last: 0};

        fifo_clr = 1'b0;
        bus.len_sel = 1'b0;
        do_reset();
        fill(132, 1'b0);
        foreach (vecs[i]) begin
            bus.computation_done = vecs[i].cd;
            bus.len_sel = vecs[i].ls;
            bus.out_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_sel", i),   32'(bus.out_sel),   32'(vecs[i].e_sel));
            chk($sformatf("vec%0d_data", i),  32'(bus.out_data),  32'(vecs[i].e_data));
            chk($sformatf("vec%0d_rdreq", i), 32'(bus.rdreq_subblock), 32'(vecs[i].e_rdreq));
            chk($sformatf("vec%0d_busy", i),  32'(bus.busy),      32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_last", i),  32'(bus.out_last),  32'(vecs[i].e_last));
            tick();
        end
        do_reset();

        run_frame(1'b0, 1'b0, -1);
        run_frame(1'b1, 1'b0, -1);
        run_frame(1'b0, 1'b1, -1);
        run_frame(1'b1, 1'b1, -1);
        run_frame(1'b0, 1'b0, 50);
        run_frame(1'b0, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
